// File: rtl/oled_sel_pkg.sv
// Shared selector codes, colours and state encoding for the OLED pixel-source selector.
package oled_sel_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_A   = 3'd0;
  localparam sel_t SEL_B   = 3'd1;
  localparam sel_t SEL_C   = 3'd2;
  localparam sel_t SEL_D   = 3'd3;
  localparam sel_t SEL_INV = 3'd4;

  localparam logic [15:0] COL_BLACK   = 16'h0000;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // Only a single raised switch selects a source; anything else is invalid.
  function automatic sel_t decode_sw(input logic [3:0] sw);
    case (sw)
      4'b0001: return SEL_A;
      4'b0010: return SEL_B;
      4'b0100: return SEL_C;
      4'b1000: return SEL_D;
      default: return SEL_INV;
    endcase
  endfunction

endpackage

// File: rtl/sel_stability_filter.sv
// Synchronises the slide switches, decodes them and qualifies the selection
// over consecutive frame_begin samples.
module sel_stability_filter
  import oled_sel_pkg::*;
#(
  parameter int STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_begin,
  input  logic [3:0] sw,
  output sel_t       candidate,
  output logic       qualified
);

  localparam int CW = $clog2(STABLE_FRAMES + 2);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  sel_t          cand_q, cand_d;
  sel_t          dec;
  logic [CW-1:0] stable_q, stable_d;

  always_comb begin
    sync1_d  = sw;
    sync2_d  = sync1_q;
    dec      = decode_sw(sync2_q);
    cand_d   = cand_q;
    stable_d = stable_q;
    if (frame_begin) begin
      if (dec == cand_q) begin
        if (stable_q < CW'(STABLE_FRAMES)) stable_d = stable_q + CW'(1);
      end else begin
        cand_d   = dec;
        stable_d = CW'(1);
      end
    end
    // The commit FSM acts on this edge, so it sees the next-state values.
    candidate = cand_d;
    qualified = frame_begin && (stable_d == CW'(STABLE_FRAMES));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      cand_q   <= SEL_INV;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/oled_source_selector.sv
// Frame-synchronous pixel-source selector: commits a qualified switch selection
// on frame_begin, blanks for whole frames after a change and registers the pixel.
module oled_source_selector
  import oled_sel_pkg::*;
#(
  parameter int          STABLE_FRAMES  = 3,
  parameter int          BLANK_FRAMES   = 2,
  parameter logic [15:0] INVALID_COLOUR = COL_MAGENTA,
  parameter logic [15:0] BLANK_COLOUR   = COL_BLACK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_begin,
  input  logic [3:0]  sw,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic [15:0] data_c,
  input  logic [15:0] data_d,
  output logic [15:0] pixel_data,
  output logic [2:0]  active_sel,
  output logic        switching
);

  localparam int BW = $clog2(BLANK_FRAMES + 2);

  sel_t          candidate;
  logic          qualified;
  logic [0:0]    state_q, state_d;
  sel_t          active_q, active_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [15:0]   pixel_q, pixel_d;
  logic          switching_q, switching_d;

  sel_stability_filter #(.STABLE_FRAMES(STABLE_FRAMES)) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_begin(frame_begin),
    .sw         (sw),
    .candidate  (candidate),
    .qualified  (qualified)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    blank_d  = blank_q;
    if (frame_begin) begin
      if (state_q == ST_RUN) begin
        if (qualified && (candidate != active_q)) begin
          active_d = candidate;
          if (BLANK_FRAMES > 0) begin
            state_d = ST_BLANK;
            blank_d = BW'(BLANK_FRAMES);
          end
        end
      end else if (blank_q == BW'(1)) begin
        state_d = ST_RUN;
      end else begin
        blank_d = blank_q - BW'(1);
      end
    end
    switching_d = (state_d == ST_BLANK);

    if (state_q == ST_BLANK) begin
      pixel_d = BLANK_COLOUR;
    end else begin
      case (active_q)
        SEL_A:   pixel_d = data_a;
        SEL_B:   pixel_d = data_b;
        SEL_C:   pixel_d = data_c;
        SEL_D:   pixel_d = data_d;
        default: pixel_d = INVALID_COLOUR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      active_q    <= SEL_INV;
      blank_q     <= '0;
      pixel_q     <= 16'h0000;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      blank_q     <= blank_d;
      pixel_q     <= pixel_d;
      switching_q <= switching_d;
    end
  end

  assign pixel_data = pixel_q;
  assign active_sel = active_q;
  assign switching  = switching_q;

endmodule

// File: tb/tb_oled_source_selector.sv
// Directed bench for oled_source_selector: default build plus a no-blanking build.
module tb_oled_source_selector;

  localparam logic [15:0] DA = 16'h07E0;
  localparam logic [15:0] DB = 16'h001F;
  localparam logic [15:0] DC = 16'hFFE0;
  localparam logic [15:0] DD = 16'hF800;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_begin;
  logic [3:0]  sw, sw0;
  logic [15:0] data_a, data_b, data_c, data_d;
  logic [15:0] pixel_data, pixel0;
  logic [2:0]  active_sel, active0;
  logic        switching, switching0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oled_source_selector dut (
    .clk(clk), .reset_n(reset_n), .frame_begin(frame_begin), .sw(sw),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .pixel_data(pixel_data), .active_sel(active_sel), .switching(switching)
  );

  oled_source_selector #(.BLANK_FRAMES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .frame_begin(frame_begin), .sw(sw0),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .pixel_data(pixel0), .active_sel(active0), .switching(switching0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_begin for exactly one edge; returns 1 time unit after that edge.
  task automatic frame_edge();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
  endtask

  task automatic frame();
    repeat (199) tick();
    frame_edge();
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_begin = 1'b0;
    sw          = 4'b0001;
    sw0         = 4'b0001;
    data_a = DA; data_b = DB; data_c = DC; data_d = DD;

    // 1: power-up, qualify A, two blank frames
    repeat (3) tick();
    check("rst_pixel", pixel_data, 16'h0000);
    check("rst_active", {13'd0, active_sel}, 16'd4);
    check("rst_switching", {15'd0, switching}, 16'd0);
    reset_n = 1'b1;
    tick();
    check("t1_invalid_pixel", pixel_data, 16'hF81F);
    frame();
    frame();
    check("t1_pre_commit_active", {13'd0, active_sel}, 16'd4);
    check("t1_pre_commit_pixel", pixel_data, 16'hF81F);
    frame();
    check("t1_commit_active", {13'd0, active_sel}, 16'd0);
    check("t1_commit_switching", {15'd0, switching}, 16'd1);
    check("t1_commit_edge_pixel", pixel_data, 16'hF81F);
    check("t6_boot_active0", {13'd0, active0}, 16'd0);
    check("t6_boot_switching0", {15'd0, switching0}, 16'd0);
    tick();
    check("t1_blank_pixel", pixel_data, 16'h0000);
    check("t6_boot_pixel0", pixel0, DA);
    frame();
    check("t1_blank2_switching", {15'd0, switching}, 16'd1);
    tick();
    check("t1_blank2_pixel", pixel_data, 16'h0000);
    frame();
    check("t1_end_blank_switching", {15'd0, switching}, 16'd0);
    check("t1_end_blank_pixel", pixel_data, 16'h0000);
    tick();
    check("t1_run_pixel_a", pixel_data, DA);

    // 2: single-frame glitch to B is rejected
    sw = 4'b0010;
    frame();
    sw = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      frame();
      check("t2_active", {13'd0, active_sel}, 16'd0);
      check("t2_switching", {15'd0, switching}, 16'd0);
    end
    tick();
    check("t2_pixel", pixel_data, DA);

    // 3: two switches up -> invalid after qualification
    sw = 4'b0011;
    frame();
    frame();
    check("t3_pre_commit_active", {13'd0, active_sel}, 16'd0);
    frame();
    check("t3_commit_active", {13'd0, active_sel}, 16'd4);
    check("t3_commit_switching", {15'd0, switching}, 16'd1);
    tick();
    check("t3_blank_pixel", pixel_data, 16'h0000);
    frame();
    frame();
    check("t3_end_switching", {15'd0, switching}, 16'd0);
    tick();
    check("t3_invalid_pixel", pixel_data, 16'hF81F);

    // 4: settle on A, move to D, change to B during D's blanking
    sw = 4'b0001;
    repeat (5) frame();
    check("t4_settled_a", {13'd0, active_sel}, 16'd0);
    check("t4_settled_run", {15'd0, switching}, 16'd0);
    sw = 4'b1000;
    repeat (3) frame();
    check("t4_commit_d", {13'd0, active_sel}, 16'd3);
    check("t4_commit_d_switching", {15'd0, switching}, 16'd1);
    sw = 4'b0010;
    frame();
    check("t4_blank_keeps_d", {13'd0, active_sel}, 16'd3);
    frame();
    check("t4_back_run_d", {13'd0, active_sel}, 16'd3);
    check("t4_back_run_switching", {15'd0, switching}, 16'd0);
    tick();
    check("t4_pixel_d", pixel_data, DD);
    frame();
    check("t4_commit_b", {13'd0, active_sel}, 16'd1);
    check("t4_commit_b_switching", {15'd0, switching}, 16'd1);
    tick();
    check("t4_blank_b_pixel", pixel_data, 16'h0000);
    frame();
    frame();
    tick();
    check("t4_pixel_b", pixel_data, DB);

    // 5: asynchronous reset in the middle of blanking
    sw = 4'b0100;
    repeat (3) frame();
    check("t5_commit_c_switching", {15'd0, switching}, 16'd1);
    repeat (50) tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("t5_rst_pixel", pixel_data, 16'h0000);
    check("t5_rst_switching", {15'd0, switching}, 16'd0);
    check("t5_rst_active", {13'd0, active_sel}, 16'd4);
    tick();
    tick();
    reset_n = 1'b1;
    frame();
    frame();
    check("t5_requalify_active", {13'd0, active_sel}, 16'd4);
    frame();
    check("t5_recommit_c", {13'd0, active_sel}, 16'd2);
    check("t5_recommit_switching", {15'd0, switching}, 16'd1);

    // 6: no-blanking build, A -> B
    tick();
    check("t6_pixel0_a", pixel0, DA);
    sw0 = 4'b0010;
    frame();
    frame();
    check("t6_pre_commit_active0", {13'd0, active0}, 16'd0);
    repeat (199) tick();
    check("t6_before_edge_pixel0", pixel0, DA);
    frame_edge();
    check("t6_commit_active0", {13'd0, active0}, 16'd1);
    check("t6_commit_switching0", {15'd0, switching0}, 16'd0);
    check("t6_commit_edge_pixel0", pixel0, DA);
    tick();
    check("t6_pixel0_b", pixel0, DB);
    check("t6_after_switching0", {15'd0, switching0}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
